// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : Registered two-entry skid buffer for add/sub results and flags.
//             Optional sticky flags are enabled by ALU_RESULT_STICKY_FLAGS_EN.
//  Revision : 1.0
// ============================================================================
module alu_result_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry_or_borrow,
   input  logic             in_zero,
   input  logic             in_negative,
   input  logic             in_overflow,
   input  logic             in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_or_borrow_out,
   output logic             zero_flag,
   output logic             negative_flag,
   output logic             overflow_flag,
   output logic             sel_out,
   input  logic             clear_sticky,
   output logic             sticky_overflow,
   output logic             sticky_carry
);

   localparam int c_beat_w = WIDTH + 5;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [c_beat_w-1:0] main_q, main_d;
   logic [c_beat_w-1:0] skid_q, skid_d;
   logic [c_beat_w-1:0] w_beat;
   logic                in_ready_q;
   logic                w_accept;
   logic                w_deliver;

   assign w_beat    = {in_sel, in_overflow, in_negative, in_zero, in_carry_or_borrow, in_result};
   assign w_accept  = in_valid && in_ready_q;
   assign w_deliver = (state_q != S_EMPTY) && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (w_accept) begin
               main_d  = w_beat;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (w_accept && w_deliver) begin
               main_d = w_beat;
            end else if (w_accept) begin
               skid_d  = w_beat;
               state_d = S_FULL;
            end else if (w_deliver) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so only the drain path is possible
            if (w_deliver) begin
               main_d  = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != S_FULL);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != S_EMPTY);
   assign {sel_out, overflow_flag, negative_flag, zero_flag, carry_or_borrow_out, result} = main_q;

`ifdef ALU_RESULT_STICKY_FLAGS_EN
   logic sticky_ov_q;
   logic sticky_cy_q;

   // A set in the same cycle as clear_sticky takes priority over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ov_q <= 1'b0;
         sticky_cy_q <= 1'b0;
      end else begin
         if (w_accept && in_overflow) begin
            sticky_ov_q <= 1'b1;
         end else if (clear_sticky) begin
            sticky_ov_q <= 1'b0;
         end
         if (w_accept && in_carry_or_borrow) begin
            sticky_cy_q <= 1'b1;
         end else if (clear_sticky) begin
            sticky_cy_q <= 1'b0;
         end
      end
   end

   assign sticky_overflow = sticky_ov_q;
   assign sticky_carry    = sticky_cy_q;
`else
   logic w_unused_clear;

   assign w_unused_clear  = clear_sticky;
   assign sticky_overflow = 1'b0;
   assign sticky_carry    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Randomized and directed self-checking bench for alu_result_stage.
//  Revision : 1.0
// ============================================================================
module tb_alu_result_stage;

   localparam int WIDTH = 4;
`ifdef ALU_RESULT_STICKY_FLAGS_EN
   localparam bit c_sticky = 1'b1;
`else
   localparam bit c_sticky = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_result = '0;
   logic             in_carry_or_borrow = 1'b0;
   logic             in_zero = 1'b0;
   logic             in_negative = 1'b0;
   logic             in_overflow = 1'b0;
   logic             in_sel = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic             carry_or_borrow_out, zero_flag, negative_flag, overflow_flag, sel_out;
   logic             clear_sticky = 1'b0;
   logic             sticky_overflow, sticky_carry;

   alu_result_stage #(.WIDTH(WIDTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_result          (in_result),
      .in_carry_or_borrow (in_carry_or_borrow),
      .in_zero            (in_zero),
      .in_negative        (in_negative),
      .in_overflow        (in_overflow),
      .in_sel             (in_sel),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .result             (result),
      .carry_or_borrow_out(carry_or_borrow_out),
      .zero_flag          (zero_flag),
      .negative_flag      (negative_flag),
      .overflow_flag      (overflow_flag),
      .sel_out            (sel_out),
      .clear_sticky       (clear_sticky),
      .sticky_overflow    (sticky_overflow),
      .sticky_carry       (sticky_carry)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             cy;
      logic             z;
      logic             n;
      logic             ov;
      logic             sel;
   } beat_t;

   beat_t mq[$];
   bit    m_ready    = 1'b0;
   bit    m_last_acc = 1'b0;
   bit    m_sov      = 1'b0;
   bit    m_scy      = 1'b0;
   bit    cmp_en     = 1'b0;
   int    n_checks   = 0;
   int    n_pass     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a FIFO of at most two beats; the head is what the outputs show.
   always @(posedge clk or posedge rst) begin : p_model
      bit acc;
      bit del;
      if (rst) begin
         mq.delete();
         m_ready    = 1'b0;
         m_last_acc = 1'b0;
         m_sov      = 1'b0;
         m_scy      = 1'b0;
      end else begin
         acc = in_valid && m_ready;
         del = (mq.size() > 0) && out_ready;
         if (del) void'(mq.pop_front());
         if (acc) mq.push_back('{in_result, in_carry_or_borrow, in_zero, in_negative, in_overflow, in_sel});
         m_sov      = c_sticky && ((acc && in_overflow) || (m_sov && !clear_sticky));
         m_scy      = c_sticky && ((acc && in_carry_or_borrow) || (m_scy && !clear_sticky));
         m_ready    = (mq.size() < 2);
         m_last_acc = acc;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out_valid", out_valid, (mq.size() > 0));
         chk("in_ready", in_ready, m_ready);
         chk("sticky_overflow", sticky_overflow, m_sov);
         chk("sticky_carry", sticky_carry, m_scy);
         if (mq.size() > 0) begin
            chk("result", result, mq[0].res);
            chk("carry_or_borrow_out", carry_or_borrow_out, mq[0].cy);
            chk("zero_flag", zero_flag, mq[0].z);
            chk("negative_flag", negative_flag, mq[0].n);
            chk("overflow_flag", overflow_flag, mq[0].ov);
            chk("sel_out", sel_out, mq[0].sel);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [WIDTH-1:0] r, input logic cy, input logic z,
                        input logic n, input logic ov, input logic sel);
      in_valid           = 1'b1;
      in_result          = r;
      in_carry_or_borrow = cy;
      in_zero            = z;
      in_negative        = n;
      in_overflow        = ov;
      in_sel             = sel;
   endtask

   initial begin
      cmp_en = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("ready_after_reset", in_ready, 1);

      // single beat: 8 with overflow and negative driven high
      out_ready = 1'b1;
      drive(4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      chk("t1_out_valid", out_valid, 1);
      chk("t1_result", result, 8);
      chk("t1_overflow", overflow_flag, 1);
      chk("t1_negative", negative_flag, 1);
      chk("t1_sel", sel_out, 0);

      for (int v = 1; v <= 4; v++) begin
         drive(WIDTH'(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         step();
         chk("stream_result", result, v);
         chk("stream_in_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_drained", out_valid, 0);

      // stall: 5 then 6 fill the buffer, 7 is refused
      out_ready = 1'b0;
      drive(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("stall_r5", result, 5);
      drive(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("full_ready", in_ready, 0);
      drive(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("full_hold_r5", result, 5);
      chk("full_ready2", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("drain_r6", result, 6);
      chk("drain_ready", in_ready, 1);
      step();
      chk("drain_empty", out_valid, 0);

      // reset while holding 9, A
      out_ready = 1'b0;
      drive(4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      drive(4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      chk("pre_rst_ready", in_ready, 0);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {carry_or_borrow_out, zero_flag, negative_flag, overflow_flag, sel_out}, 0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         step();
         chk("no_replay", out_valid, 0);
      end

      // sticky flags
      drive(4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      drive(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      in_valid = 1'b0;
      chk("sticky_ov_held", sticky_overflow, c_sticky);
      chk("sticky_cy_held", sticky_carry, c_sticky);
      drive(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      clear_sticky = 1'b1;
      step();
      in_valid     = 1'b0;
      clear_sticky = 1'b0;
      chk("sticky_set_wins", sticky_overflow, c_sticky);
      chk("sticky_cy_cleared", sticky_carry, 0);
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      chk("sticky_clear", sticky_overflow, 0);

      // randomized traffic; upstream holds a beat until it is taken
      for (int i = 0; i < 3000; i++) begin
         if (!(in_valid && !m_last_acc)) begin
            in_valid           = ($urandom_range(0, 9) < 7);
            in_result          = WIDTH'($urandom);
            in_carry_or_borrow = 1'($urandom);
            in_zero            = 1'($urandom);
            in_negative        = 1'($urandom);
            in_overflow        = 1'($urandom);
            in_sel             = 1'($urandom);
         end
         out_ready    = ($urandom_range(0, 9) < 6);
         clear_sticky = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         step();
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
